tone_sequencer: RTL and testbench
=================================

TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 Parameter FREQ_W, default 8, width of the frequency word driven to the square-wave generator.
REQ-002 Parameter DUR_W, default 8, width of the per-step duration field, in clock cycles.
REQ-003 Parameter DEPTH, default 8, number of step-table entries; AW = clog2(DEPTH).
REQ-004 clk  input  1  single clock; all logic is rising-edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 start  input  1  one-cycle request to begin playing the table.
REQ-007 stop  input  1  abort request.
REQ-008 num_steps  input  AW+1  count of entries to play, sampled at start.
REQ-009 wr_en, wr_addr[AW], wr_freq[FREQ_W], wr_dur[DUR_W]  inputs  table write port.
REQ-010 freq  output  FREQ_W  frequency word driven to the square-wave generator.
REQ-011 wave_en  output  1  high while the current step is a tone (freq != 0).
REQ-012 busy, done  outputs  1  status: sequence active; one-cycle completion pulse.
REQ-013 step_idx  output  AW  index of the step currently playing.

Function
REQ-014 The step table SHALL be a DEPTH-entry register array {freq, dur}; wr_en writes it in 1 cycle and is accepted in any state.
REQ-015 FSM states SHALL be IDLE, PLAY, DONE.
REQ-016 IDLE + start: latch N = min(num_steps, DEPTH). If N = 0, go to DONE; otherwise go to PLAY with step_idx = 0, and load entry 0 into freq and the duration counter.
REQ-017 Entry load: freq <= entry.freq; cnt <= max(entry.dur, 1); wave_en <= (entry.freq != 0). A freq of 0 is a rest.
REQ-018 In PLAY, cnt SHALL decrement each cycle. At cnt = 1, the next entry loads on the following edge with no gap cycle, so each step lasts exactly max(dur, 1) cycles.
REQ-019 At cnt = 1 on step N-1, go to DONE. DONE lasts 1 cycle with done = 1, busy = 0, wave_en = 0 and freq = 0, then returns to IDLE.
REQ-020 busy SHALL be 1 exactly while in PLAY.
REQ-021 start while in PLAY or DONE SHALL be ignored.
REQ-022 stop in PLAY SHALL go to IDLE on the next edge with no done pulse, and freq, wave_en and step_idx cleared. stop has priority over step advance.
REQ-023 A write to the entry currently playing SHALL NOT alter the latched freq or cnt; it takes effect on that entry's next load.
REQ-024 start and stop asserted in the same cycle in IDLE: stop wins and no sequence begins.
REQ-025 Outputs SHALL be registered; freq updates on the same edge as step_idx.

Reset
REQ-026 rst SHALL force IDLE and clear freq, wave_en, busy, done, step_idx, cnt, the latched N, and every table entry to 0.
REQ-027 rst SHALL override all other inputs, including mid-PLAY and same-cycle writes.

Configuration
REQ-028 With macro TONE_SEQ_LOOP_EN defined:
- an input port loop_mode (1 bit) exists and is latched at start;
- if latched loop_mode = 1, completing step N-1 wraps to step 0 with no gap and no done pulse, until stop or rst.
REQ-029 With TONE_SEQ_LOOP_EN undefined, the loop_mode port SHALL be absent and every sequence SHALL be one-shot as in REQ-019.

Verification
REQ-030 Write e0 = {4, 3}, e1 = {0, 2}, e2 = {9, 1}; start with num_steps = 3 -> freq = 4 for 3 cycles, 0 with wave_en = 0 for 2 cycles, 9 for 1 cycle, then done for 1 cycle; busy high for 6 cycles.
REQ-031 Entry with dur = 0 and num_steps = 1 -> 1-cycle step, then done.
REQ-032 start with num_steps = 0 -> done on the next cycle, busy never high. start with num_steps = 12 and DEPTH = 8 -> exactly 8 steps play.
REQ-033 stop during step 1 -> idle on the next cycle, outputs 0, no done; start during PLAY -> no effect.
REQ-034 Rewrite the playing entry mid-step -> current freq unchanged; rst mid-PLAY -> all outputs 0 and a re-read of the table via replay shows zeros.
REQ-035 With TONE_SEQ_LOOP_EN and loop_mode = 1, 2 steps of dur 2 -> step_idx sequence 0,0,1,1,0,0,... with no done until stop.

Source files
------------

// File: rtl/tone_sequencer.sv
// Table-driven tone sequencer: plays {freq, dur} steps back to back.
// Optional TONE_SEQ_LOOP_EN adds loop_mode for continuous replay.
module tone_sequencer #(
  parameter int FREQ_W = 8,
  parameter int DUR_W  = 8,
  parameter int DEPTH  = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [AW:0]       num_steps,
`ifdef TONE_SEQ_LOOP_EN
  input  logic              loop_mode,
`endif
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [FREQ_W-1:0] wr_freq,
  input  logic [DUR_W-1:0]  wr_dur,
  output logic [FREQ_W-1:0] freq,
  output logic              wave_en,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     step_idx
);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_e;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [FREQ_W-1:0] tab_f_q [DEPTH];
  logic [DUR_W-1:0]  tab_d_q [DEPTH];
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic              wave_q, wave_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [AW-1:0]     idx_q, idx_d, ld_idx;
  logic [DUR_W-1:0]  cnt_q, cnt_d;
  logic [AW:0]       n_q, n_d, n_sel;
  logic              loop_q, loop_d, loop_in;
  logic              do_load, last_step;

`ifdef TONE_SEQ_LOOP_EN
  assign loop_in = loop_mode;
`else
  assign loop_in = 1'b0;
`endif

  assign n_sel     = (num_steps > DEPTH_W) ? DEPTH_W : num_steps;
  assign last_step = ({1'b0, idx_q} == (n_q - 1'b1));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tab_f_q[i] <= '0;
        tab_d_q[i] <= '0;
      end
    end else if (wr_en && ({1'b0, wr_addr} < DEPTH_W)) begin
      tab_f_q[wr_addr] <= wr_freq;
      tab_d_q[wr_addr] <= wr_dur;
    end
  end

  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    wave_d  = wave_q;
    done_d  = 1'b0;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    loop_d  = loop_q;
    do_load = 1'b0;
    ld_idx  = '0;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          n_d    = n_sel;
          loop_d = loop_in;
          if (n_sel == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = PLAY;
            do_load = 1'b1;
          end
        end
      end
      PLAY: begin
        if (stop) begin
          state_d = IDLE;
          freq_d  = '0;
          wave_d  = 1'b0;
          idx_d   = '0;
        end else if (cnt_q == DUR_W'(1)) begin
          if (!last_step) begin
            do_load = 1'b1;
            ld_idx  = idx_q + 1'b1;
          end else if (loop_q) begin
            do_load = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            freq_d  = '0;
            wave_d  = 1'b0;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // zero durations still occupy one cycle
    if (do_load) begin
      idx_d  = ld_idx;
      freq_d = tab_f_q[ld_idx];
      wave_d = (tab_f_q[ld_idx] != '0);
      cnt_d  = (tab_d_q[ld_idx] == '0) ? DUR_W'(1) : tab_d_q[ld_idx];
    end
    busy_d = (state_d == PLAY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      freq_q  <= '0;
      wave_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      loop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      freq_q  <= freq_d;
      wave_q  <= wave_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      loop_q  <= loop_d;
    end
  end

  assign freq     = freq_q;
  assign wave_en  = wave_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign step_idx = idx_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: directed scenarios plus random traffic
// checked every cycle against an elapsed-time step model.
module tb_tone_sequencer;
  localparam int FREQ_W = 8;
  localparam int DUR_W  = 8;
  localparam int DEPTH  = 8;
  localparam int AW     = 3;

  logic              clk = 1'b0;
  logic              rst, start, stop, wr_en, loop_mode;
  logic [AW:0]       num_steps;
  logic [AW-1:0]     wr_addr;
  logic [FREQ_W-1:0] wr_freq;
  logic [DUR_W-1:0]  wr_dur;
  logic [FREQ_W-1:0] freq;
  logic              wave_en, busy, done;
  logic [AW-1:0]     step_idx;

  tone_sequencer #(.FREQ_W(FREQ_W), .DUR_W(DUR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .num_steps(num_steps),
`ifdef TONE_SEQ_LOOP_EN
    .loop_mode(loop_mode),
`endif
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_freq(wr_freq),
    .wr_dur(wr_dur), .freq(freq), .wave_en(wave_en),
    .busy(busy), .done(done), .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: which step is playing, how long it has run, its length
  bit m_act, m_done, m_loop;
  int m_k, m_el, m_len, m_freq, m_n;
  int tf [DEPTH];
  int td [DEPTH];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic mload(int j);
    m_k    = j;
    m_el   = 0;
    m_len  = (td[j] == 0) ? 1 : td[j];
    m_freq = tf[j];
  endtask

  task automatic model_step();
    bit nd;
    nd = 0;
    if (rst) begin
      m_act = 0; m_done = 0; m_loop = 0;
      m_k = 0; m_el = 0; m_len = 0; m_freq = 0; m_n = 0;
      for (int i = 0; i < DEPTH; i++) begin
        tf[i] = 0;
        td[i] = 0;
      end
      return;
    end
    if (m_act) begin
      if (stop) m_act = 0;
      else begin
        m_el++;
        if (m_el == m_len) begin
          if (m_k == m_n - 1) begin
            if (m_loop) mload(0);
            else begin
              m_act = 0;
              nd = 1;
            end
          end else mload(m_k + 1);
        end
      end
    end else if (!m_done && start && !stop) begin
      m_n = (int'(num_steps) > DEPTH) ? DEPTH : int'(num_steps);
`ifdef TONE_SEQ_LOOP_EN
      m_loop = loop_mode;
`else
      m_loop = 0;
`endif
      if (m_n == 0) nd = 1;
      else begin
        m_act = 1;
        mload(0);
      end
    end
    if (wr_en) begin
      tf[wr_addr] = int'(wr_freq);
      td[wr_addr] = int'(wr_dur);
    end
    m_done = nd;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("freq", int'(freq), m_act ? m_freq : 0);
    chk("wave_en", int'(wave_en), (m_act && m_freq != 0) ? 1 : 0);
    chk("busy", int'(busy), int'(m_act));
    chk("done", int'(done), int'(m_done));
    chk("step_idx", int'(step_idx), m_act ? m_k : 0);
  endtask

  task automatic wr(int a, int f, int d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_freq = FREQ_W'(f);
    wr_dur  = DUR_W'(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic go(int n);
    start     = 1'b1;
    num_steps = (AW+1)'(n);
    tick();
    start = 1'b0;
  endtask

  int exp_f [6] = '{4, 4, 4, 0, 0, 9};
  int exp_i [8] = '{0, 0, 1, 1, 0, 0, 1, 1};

  initial begin
    int bc, last, dn;
    rst = 1'b1; start = 1'b0; stop = 1'b0; wr_en = 1'b0;
    loop_mode = 1'b0; num_steps = '0;
    wr_addr = '0; wr_freq = '0; wr_dur = '0;
    tick(); tick();
    chk("rst_freq", int'(freq), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_idx", int'(step_idx), 0);
    rst = 1'b0;
    tick();

    // three-step melody including a rest
    wr(0, 4, 3); wr(1, 0, 2); wr(2, 9, 1);
    go(3);
    for (int i = 0; i < 6; i++) begin
      chk("mel_freq", int'(freq), exp_f[i]);
      chk("mel_wave", int'(wave_en), (exp_f[i] != 0) ? 1 : 0);
      chk("mel_busy", int'(busy), 1);
      tick();
    end
    chk("mel_done", int'(done), 1);
    chk("mel_busy_end", int'(busy), 0);
    tick(); tick();

    // zero duration plays one cycle
    wr(0, 5, 0);
    go(1);
    chk("d0_freq", int'(freq), 5);
    tick();
    chk("d0_done", int'(done), 1);
    tick();

    // empty sequence
    go(0);
    chk("n0_done", int'(done), 1);
    chk("n0_busy", int'(busy), 0);
    tick();
    chk("n0_done2", int'(done), 0);

    // oversize count clamps to DEPTH
    for (int i = 0; i < DEPTH; i++) wr(i, i + 1, 1);
    go(12);
    bc = 0; last = 0; dn = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy) begin
        bc++;
        last = int'(step_idx);
      end
      if (done) dn++;
      tick();
    end
    chk("clamp_cycles", bc, 8);
    chk("clamp_last", last, 7);
    chk("clamp_done", dn, 1);

    // stop in step 1, start while playing ignored
    wr(0, 1, 2); wr(1, 2, 3); wr(2, 3, 2);
    go(3);
    tick(); tick();
    start = 1'b1; num_steps = 4'd1;
    tick();
    start = 1'b0;
    chk("ign_freq", int'(freq), 2);
    chk("ign_idx", int'(step_idx), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_busy", int'(busy), 0);
    chk("stop_freq", int'(freq), 0);
    chk("stop_done", int'(done), 0);
    tick();
    chk("stop_done2", int'(done), 0);

    // rewrite playing entry, then reset mid-play
    go(3);
    wr(0, 7, 5);
    chk("rw_freq", int'(freq), 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstp_busy", int'(busy), 0);
    chk("rstp_freq", int'(freq), 0);
    chk("rstp_idx", int'(step_idx), 0);
    go(3);
    chk("zero_busy", int'(busy), 1);
    chk("zero_freq", int'(freq), 0);
    chk("zero_wave", int'(wave_en), 0);
    tick(); tick(); tick();
    chk("zero_done", int'(done), 1);
    tick();

`ifdef TONE_SEQ_LOOP_EN
    wr(0, 3, 2); wr(1, 5, 2);
    loop_mode = 1'b1;
    go(2);
    loop_mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("loop_idx", int'(step_idx), exp_i[i]);
      chk("loop_done", int'(done), 0);
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("loop_stop", int'(busy), 0);
    tick();
`endif

    for (int c = 0; c < 4000; c++) begin
      start     = ($urandom_range(0, 9) == 0);
      stop      = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      wr_en     = ($urandom_range(0, 3) == 0);
      wr_addr   = AW'($urandom_range(0, DEPTH - 1));
      wr_freq   = ($urandom_range(0, 3) == 0) ? '0
                  : FREQ_W'($urandom_range(1, 255));
      wr_dur    = DUR_W'($urandom_range(0, 4));
      num_steps = (AW+1)'($urandom_range(0, 12));
      loop_mode = 1'($urandom_range(0, 1));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
